// File: rtl/vedic_64_div.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit per clock.
// Optional macro VEDIC_DIV_OVF_BYPASS_EN sends overflow operations straight to DONE.
module vedic_64_div #(
    parameter int W = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           overflow
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        r_state;
    logic [W-1:0]  r_d;
    logic [W-1:0]  r_r;
    logic [W-1:0]  r_s;
    logic [CW-1:0] r_cnt;
    logic          r_ovf;

    logic [W:0]    w_t;
    logic          w_bit;
    logic [W-1:0]  w_diff;
    logic [W-1:0]  w_rNext;
    logic [W-1:0]  w_sNext;
    logic          w_ovfIn;

    // The trial value is one bit wider than the divisor so the compare never truncates.
    // The subtraction only needs the low W bits: whenever the quotient fits, T - D < 2^W.
    assign w_t     = {r_r, r_s[W-1]};
    assign w_bit   = (w_t >= {1'b0, r_d});
    assign w_diff  = w_t[W-1:0] - r_d;
    assign w_rNext = w_bit ? w_diff : w_t[W-1:0];
    // Dividend bits leave the top of S while quotient bits enter at the bottom.
    assign w_sNext = {r_s[W-2:0], w_bit};
    assign w_ovfIn = (dividend[2*W-1:W] >= divisor);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            overflow  <= 1'b0;
            r_d       <= '0;
            r_r       <= '0;
            r_s       <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        r_d      <= divisor;
                        r_r      <= dividend[2*W-1:W];
                        r_s      <= dividend[W-1:0];
                        r_cnt    <= '0;
                        r_ovf    <= w_ovfIn;
                        in_ready <= 1'b0;
`ifdef VEDIC_DIV_OVF_BYPASS_EN
                        if (w_ovfIn) begin
                            r_state   <= DONE;
                            out_valid <= 1'b1;
                            quotient  <= '1;
                            remainder <= '0;
                            overflow  <= 1'b1;
                        end else begin
                            r_state <= CALC;
                        end
`else
                        r_state <= CALC;
`endif
                    end
                end
                CALC: begin
                    r_r   <= w_rNext;
                    r_s   <= w_sNext;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ITER) begin
                        r_state   <= DONE;
                        out_valid <= 1'b1;
                        overflow  <= r_ovf;
                        quotient  <= r_ovf ? '1 : w_sNext;
                        remainder <= r_ovf ? '0 : w_rNext;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state   <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
